// File: rtl/pc_quantum_sched.sv
// pc_quantum_sched
// Program-counter unit for the single-cycle core. It holds the PC, picks the
// next PC (sequential, target or return-to-epc) and counts user-mode
// instructions against a programmable quantum. When the quantum runs out it
// forces entry to the OS and saves the interrupted PC in epc.
//
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   stall          freeze the unit this cycle (quantum load still allowed)
//   pc_sel         00 seq, 01 target, 10 epc, 11 seq
//   target         jump/branch destination
//   halt           halt instruction retiring this cycle
//   qtm_load       load qtm_value as the new quantum limit (0 = no preemption)
//   preempt_en     global preemption enable
//   pc, epc        current PC and PC saved at last preemption
//   qtm_count      user instructions executed in the current quantum
//   in_os          pc below OS_LIMIT
//   preempted      one-cycle pulse after a preemption
//   halted         unit is in HALTED
//
// state   | meaning
// --------+-----------------------------------------------
// RUN     | executing; cycles with stall=0 advance the PC
// HALTED  | halt retired; everything frozen until reset
module pc_quantum_sched #(
  parameter int ADDR_W   = 32,
  parameter int QTM_W    = 16,
  parameter int OS_LIMIT = 616,
  parameter int OS_ENTRY = 0,
  parameter int PC_STEP  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic [1:0]        pc_sel,
  input  logic [ADDR_W-1:0] target,
  input  logic              halt,
  input  logic              qtm_load,
  input  logic [QTM_W-1:0]  qtm_value,
  input  logic              preempt_en,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] epc,
  output logic [QTM_W-1:0]  qtm_count,
  output logic              in_os,
  output logic              preempted,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] OS_LIMIT_C = ADDR_W'(OS_LIMIT);
  localparam logic [ADDR_W-1:0] OS_ENTRY_C = ADDR_W'(OS_ENTRY);
  localparam logic [ADDR_W-1:0] PC_STEP_C  = ADDR_W'(PC_STEP);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  epc_q, epc_d;
  logic [QTM_W-1:0]   qtm_limit_q, qtm_limit_d;
  logic [QTM_W-1:0]   qtm_count_q, qtm_count_d;
  logic               preempted_q, preempted_d;
  logic [ADDR_W-1:0]  pc_next;
  logic               quantum_on;
  logic               expire;

  assign in_os = (pc_q < OS_LIMIT_C);

  always_comb begin
    pc_next = pc_q + PC_STEP_C;
    unique case (pc_sel)
      2'b01:   pc_next = target;
      2'b10:   pc_next = epc_q;
      default: pc_next = pc_q + PC_STEP_C;
    endcase
  end

  // Preempt on the instruction that completes the quantum, so a user process
  // retires exactly qtm_limit instructions before the OS takes over.
  assign quantum_on = preempt_en && (qtm_limit_q != '0);
  assign expire     = !in_os && quantum_on &&
                      (qtm_count_q == qtm_limit_q - QTM_W'(1));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    epc_d       = epc_q;
    qtm_limit_d = qtm_limit_q;
    qtm_count_d = qtm_count_q;
    preempted_d = 1'b0;
    if (state_q == ST_RUN) begin
      if (!stall) begin
        if (halt) begin
          state_d = ST_HALTED;
        end else if (expire) begin
          epc_d       = pc_next;
          pc_d        = OS_ENTRY_C;
          qtm_count_d = '0;
          preempted_d = 1'b1;
        end else begin
          pc_d = pc_next;
          if (in_os) begin
            qtm_count_d = '0;
          end else if (quantum_on) begin
            qtm_count_d = qtm_count_q + QTM_W'(1);
          end
        end
      end
      // A new limit restarts the quantum, even on a stalled cycle.
      if (qtm_load) begin
        qtm_limit_d = qtm_value;
        qtm_count_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pc_q        <= OS_ENTRY_C;
      epc_q       <= '0;
      qtm_limit_q <= '0;
      qtm_count_q <= '0;
      preempted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      qtm_limit_q <= qtm_limit_d;
      qtm_count_q <= qtm_count_d;
      preempted_q <= preempted_d;
    end
  end

  assign pc        = pc_q;
  assign epc       = epc_q;
  assign qtm_count = qtm_count_q;
  assign preempted = preempted_q;
  assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pc_quantum_sched.sv
module tb_pc_quantum_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  pc_sel;
  logic [31:0] target;
  logic        halt;
  logic        qtm_load;
  logic [15:0] qtm_value;
  logic        preempt_en;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [15:0] qtm_count;
  logic        in_os;
  logic        preempted;
  logic        halted;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // behavioural model state
  longint m_pc = 0;
  longint m_epc = 0;
  int     m_lim = 0;
  int     m_cnt = 0;
  bit     m_halted = 1'b0;
  bit     m_pre = 1'b0;

  always #5 clock = ~clock;

  pc_quantum_sched dut (
    .clock      (clock),
    .reset      (reset),
    .stall      (stall),
    .pc_sel     (pc_sel),
    .target     (target),
    .halt       (halt),
    .qtm_load   (qtm_load),
    .qtm_value  (qtm_value),
    .preempt_en (preempt_en),
    .pc         (pc),
    .epc        (epc),
    .qtm_count  (qtm_count),
    .in_os      (in_os),
    .preempted  (preempted),
    .halted     (halted)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: one instruction slot per clock, described in terms of modes and
  // quantum bookkeeping rather than the DUT's registers.
  task automatic model_step();
    longint nxt;
    bit user;
    if (reset) begin
      m_pc = 0; m_epc = 0; m_lim = 0; m_cnt = 0; m_halted = 0; m_pre = 0;
      return;
    end
    m_pre = 0;
    if (m_halted) return;
    if (!stall) begin
      case (pc_sel)
        2'd1:    nxt = longint'(target);
        2'd2:    nxt = m_epc;
        default: nxt = (m_pc + 1) % 64'h1_0000_0000;
      endcase
      user = (m_pc >= 616);
      if (halt) begin
        m_halted = 1;
      end else if (user && preempt_en && m_lim != 0 && m_cnt + 1 == m_lim) begin
        m_epc = nxt; m_pc = 0; m_cnt = 0; m_pre = 1;
      end else begin
        m_pc = nxt;
        if (!user) m_cnt = 0;
        else if (preempt_en && m_lim != 0) m_cnt = m_cnt + 1;
      end
    end
    if (qtm_load) begin
      m_lim = int'(qtm_value);
      m_cnt = 0;
    end
  endtask

  always @(posedge clock) model_step();

  always @(negedge clock) begin
    if (chk_en) begin
      check("pc", 64'(pc), 64'(m_pc));
      check("epc", 64'(epc), 64'(m_epc));
      check("qtm_count", 64'(qtm_count), 64'(m_cnt));
      check("in_os", 64'(in_os), 64'(m_pc < 616));
      check("preempted", 64'(preempted), 64'(m_pre));
      check("halted", 64'(halted), 64'(m_halted));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [31:0] tgt);
    pc_sel = sel;
    target = tgt;
  endtask

  initial begin
    reset = 1; stall = 0; pc_sel = 0; target = 0; halt = 0;
    qtm_load = 0; qtm_value = 0; preempt_en = 0;
    cyc(); cyc();
    chk_en = 1;
    reset = 0;

    // 1: sequential from reset
    check("t1_pc0", 64'(pc), 0);
    check("t1_inos", 64'(in_os), 1);
    for (int i = 1; i <= 5; i++) begin
      cyc();
      check("t1_pc", 64'(pc), 64'(i));
    end
    check("t1_cnt", 64'(qtm_count), 0);
    check("t1_pre", 64'(preempted), 0);

    // 2: quantum of 3 starting at 616
    qtm_load = 1; qtm_value = 3; preempt_en = 1; drive(2'b01, 32'd616);
    cyc();
    qtm_load = 0; drive(2'b00, 0);
    check("t2_pc616", 64'(pc), 616);
    check("t2_cnt0", 64'(qtm_count), 0);
    cyc();
    check("t2_pc617", 64'(pc), 617);
    check("t2_cnt1", 64'(qtm_count), 1);
    cyc();
    check("t2_pc618", 64'(pc), 618);
    check("t2_cnt2", 64'(qtm_count), 2);
    cyc();
    check("t2_pc0", 64'(pc), 0);
    check("t2_epc", 64'(epc), 619);
    check("t2_pre1", 64'(preempted), 1);
    check("t2_cnt_clr", 64'(qtm_count), 0);
    cyc();
    check("t2_pre_pulse", 64'(preempted), 0);
    check("t2_pc1", 64'(pc), 1);

    // 3: return to epc, preempt again after 3 user instructions
    drive(2'b10, 0);
    cyc();
    drive(2'b00, 0);
    check("t3_pc619", 64'(pc), 619);
    check("t3_cnt0", 64'(qtm_count), 0);
    cyc(); cyc(); cyc();
    check("t3_pc0", 64'(pc), 0);
    check("t3_epc", 64'(epc), 622);
    check("t3_pre", 64'(preempted), 1);

    // 4: stall mid-quantum
    drive(2'b10, 0);
    cyc();
    drive(2'b00, 0);
    cyc();
    check("t4_cnt1", 64'(qtm_count), 1);
    stall = 1;
    repeat (4) cyc();
    check("t4_pc_frozen", 64'(pc), 623);
    check("t4_cnt_frozen", 64'(qtm_count), 1);
    stall = 0;
    cyc();
    check("t4_pc624", 64'(pc), 624);
    cyc();
    check("t4_pc0", 64'(pc), 0);
    check("t4_epc", 64'(epc), 625);
    check("t4_pre", 64'(preempted), 1);

    // 5: halt in the cycle the quantum would expire
    drive(2'b01, 32'd698);
    cyc();
    drive(2'b00, 0);
    cyc(); cyc();
    check("t5_pc700", 64'(pc), 700);
    check("t5_cnt2", 64'(qtm_count), 2);
    halt = 1;
    cyc();
    halt = 0;
    check("t5_halted", 64'(halted), 1);
    check("t5_pc_hold", 64'(pc), 700);
    check("t5_no_pre", 64'(preempted), 0);
    check("t5_epc", 64'(epc), 625);
    drive(2'b01, 32'd5); qtm_load = 1; qtm_value = 9;
    repeat (3) cyc();
    qtm_load = 0; drive(2'b00, 0);
    check("t5_pc_ignored", 64'(pc), 700);
    check("t5_cnt_ignored", 64'(qtm_count), 2);
    reset = 1;
    cyc();
    reset = 0;
    check("t5_rst_pc", 64'(pc), 0);
    check("t5_rst_halted", 64'(halted), 0);
    check("t5_rst_epc", 64'(epc), 0);

    // 6: no preemption with limit 0, then with preempt_en=0; PC wrap
    preempt_en = 1;
    drive(2'b01, 32'd1000);
    cyc();
    drive(2'b00, 0);
    repeat (1000) cyc();
    check("t6_pc2000", 64'(pc), 2000);
    check("t6_cnt", 64'(qtm_count), 0);
    stall = 1; qtm_load = 1; qtm_value = 2;
    cyc();
    stall = 0; qtm_load = 0; preempt_en = 0;
    check("t6_stall_load_pc", 64'(pc), 2000);
    repeat (1000) cyc();
    check("t6_pc3000", 64'(pc), 3000);
    check("t6_pre", 64'(preempted), 0);
    drive(2'b01, 32'hFFFF_FFFF);
    cyc();
    drive(2'b00, 0);
    check("t6_pcmax", 64'(pc), 64'hFFFF_FFFF);
    check("t6_user", 64'(in_os), 0);
    cyc();
    check("t6_wrap", 64'(pc), 0);
    check("t6_wrap_os", 64'(in_os), 1);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
